// File: rtl/spi_word_rx_pkg.sv
// Shared defaults and state encoding for the SPI word receiver.
// Also provides the bit-counter width helper used by the top.
package spi_word_rx_pkg;

    localparam int WORD_W_DEF      = 16;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        ST_ARM    = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    // The counter must be able to hold WORD_W+1 (the over-length saturation value).
    function automatic int cnt_width(input int word_w);
        return $clog2(word_w + 2);
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin.
// The reset value is selectable so that cs_n can come out of reset deasserted.
module spi_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_reg;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) chain_reg[gi] <= RESET_VAL;
                    else        chain_reg[gi] <= d;
                end
            end else begin : g_rest
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) chain_reg[gi] <= RESET_VAL;
                    else        chain_reg[gi] <= chain_reg[gi-1];
                end
            end
        end
    endgenerate

    assign q = chain_reg[STAGES-1];

endmodule

// File: rtl/spi_word_rx.sv
// Peripheral-side SPI receiver: oversamples cs_n/sclk/sdin, shifts MSB-first words in,
// and reports each closed frame as either a good word (rd_valid) or a length error (rd_err).
module spi_word_rx
    import spi_word_rx_pkg::*;
#(
    parameter int WORD_W      = WORD_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_cs_n,
    input  logic              spi_sclk,
    input  logic              spi_sdin,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_err,
    output logic              busy
);

    localparam int CNT_W = cnt_width(WORD_W);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WORD_W + 1);
    localparam int ARM_W = $clog2(SYNC_STAGES + 1);
    localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES);
    // Bit order in the pin/sync vectors: 0 = cs_n, 1 = sclk, 2 = sdin.
    localparam logic [2:0] SYNC_RST = 3'b001;

    logic [2:0] pin_vec;
    logic [2:0] sync_vec;
    logic       cs_s, sclk_s, sdin_s;

    assign pin_vec = {spi_sdin, spi_sclk, spi_cs_n};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            spi_sync #(
                .STAGES    (SYNC_STAGES),
                .RESET_VAL (SYNC_RST[gi])
            ) u_sync (
                .clk   (clk),
                .rst_n (rst_n),
                .d     (pin_vec[gi]),
                .q     (sync_vec[gi])
            );
        end
    endgenerate

    assign cs_s   = sync_vec[0];
    assign sclk_s = sync_vec[1];
    assign sdin_s = sync_vec[2];

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic [WORD_W-1:0] shift_reg, shift_next;
    logic [WORD_W-1:0] rd_data_reg, rd_data_next;
    logic              rd_valid_reg, rd_valid_next;
    logic              rd_err_reg, rd_err_next;
    logic              cs_d_reg, sclk_d_reg;
    logic [ARM_W-1:0]  arm_cnt_reg, arm_cnt_next;

    logic cs_fall, cs_rise, sclk_rise;
    assign cs_fall   = cs_d_reg & ~cs_s;
    assign cs_rise   = ~cs_d_reg & cs_s;
    assign sclk_rise = ~sclk_d_reg & sclk_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_ARM;
            count_reg    <= '0;
            shift_reg    <= '0;
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
            rd_err_reg   <= 1'b0;
            cs_d_reg     <= 1'b1;
            sclk_d_reg   <= 1'b0;
            arm_cnt_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            shift_reg    <= shift_next;
            rd_data_reg  <= rd_data_next;
            rd_valid_reg <= rd_valid_next;
            rd_err_reg   <= rd_err_next;
            cs_d_reg     <= cs_s;
            sclk_d_reg   <= sclk_s;
            arm_cnt_reg  <= arm_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        shift_next    = shift_reg;
        rd_data_next  = rd_data_reg;
        rd_valid_next = 1'b0;
        rd_err_next   = 1'b0;
        arm_cnt_next  = (arm_cnt_reg == ARM_DONE) ? arm_cnt_reg : arm_cnt_reg + 1'b1;

        case (state_reg)
            // The synchronizers reset to "cs_n high", so wait until they have flushed
            // before trusting cs_s; otherwise a frame open at reset release would be captured.
            ST_ARM: begin
                if (arm_cnt_reg == ARM_DONE && cs_s) state_next = ST_IDLE;
            end
            ST_IDLE: begin
                if (cs_fall) begin
                    state_next = ST_ACTIVE;
                    count_next = '0;
                    shift_next = '0;
                end
            end
            ST_ACTIVE: begin
                if (cs_rise) begin
                    state_next = ST_IDLE;
                    if (count_reg == CNT_FULL) begin
                        rd_data_next  = shift_reg;
                        rd_valid_next = 1'b1;
                    end else begin
                        rd_err_next = 1'b1;
                    end
                end else if (sclk_rise && !cs_s) begin
                    shift_next = {shift_reg[WORD_W-2:0], sdin_s};
                    if (count_reg != CNT_SAT) count_next = count_reg + 1'b1;
                end
            end
            default: state_next = ST_ARM;
        endcase
    end

    assign rd_data  = rd_data_reg;
    assign rd_valid = rd_valid_reg;
    assign rd_err   = rd_err_reg;
    assign busy     = (state_reg == ST_ACTIVE) && !cs_s;

endmodule

// File: tb/tb_spi_word_rx.sv
// Directed and randomized frames for spi_word_rx, checked against a frame-level model:
// a frame of exactly 16 bits yields that word, any other length yields one error pulse.
`timescale 1ns/1ps
module tb_spi_word_rx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        spi_cs_n, spi_sclk, spi_sdin;
    logic [15:0] rd_data;
    logic        rd_valid, rd_err, busy;

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    int          exp_err   = 0;
    int          got_err   = 0;
    int          both_cnt  = 0;
    int          consec    = 0;
    logic        prev_pulse = 1'b0;
    logic [15:0] model_data = 16'h0;

    always #10 clk = ~clk;

    spi_word_rx dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .spi_cs_n (spi_cs_n),
        .spi_sclk (spi_sclk),
        .spi_sdin (spi_sdin),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_err   (rd_err),
        .busy     (busy)
    );

    // Records output pulses only; all judgement happens in the main sequence.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_valid) got_q.push_back(rd_data);
            if (rd_err) got_err++;
            if (rd_valid && rd_err) both_cnt++;
            if ((rd_valid || rd_err) && prev_pulse) consec++;
            prev_pulse = rd_valid || rd_err;
        end else begin
            prev_pulse = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Bit-banged SPI master: data changes while sclk is low, hp = half period in clk cycles.
    task automatic send_frame(input logic [31:0] data, input int nbits, input int hp);
        spi_cs_n = 1'b0;
        spi_sclk = 1'b0;
        #(hp * 20);
        for (int i = nbits - 1; i >= 0; i--) begin
            spi_sdin = data[i];
            #(hp * 20) spi_sclk = 1'b1;
            #(hp * 20) spi_sclk = 1'b0;
        end
        #(hp * 20) spi_cs_n = 1'b1;
    endtask

    task automatic model_frame(input logic [31:0] data, input int nbits);
        if (nbits == 16) begin
            exp_q.push_back(data[15:0]);
            model_data = data[15:0];
        end else begin
            exp_err++;
        end
    endtask

    task automatic settle_check(input string tag);
        int n;
        repeat (10) @(negedge clk);
        chk({tag, "_nvalid"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk({tag, "_word"}, got_q[i], exp_q[i]);
        chk({tag, "_nerr"}, got_err, exp_err);
        chk({tag, "_rd_data"}, rd_data, model_data);
        chk({tag, "_excl"}, both_cnt + consec, 0);
        chk({tag, "_busy_after"}, busy, 1'b0);
        $display("step %s: words=%0d errs=%0d rd_data=0x%04h", tag, got_q.size(), got_err, rd_data);
        got_q.delete();
        exp_q.delete();
        got_err = 0;
        exp_err = 0;
        both_cnt = 0;
        consec = 0;
    endtask

    initial begin
        int lat;
        logic [31:0] w;
        int hp;

        rst_n = 1'b0;
        spi_cs_n = 1'b1;
        spi_sclk = 1'b0;
        spi_sdin = 1'b0;
        repeat (4) @(negedge clk);
        chk("reset_rd_data", rd_data, 16'h0);
        chk("reset_rd_valid", rd_valid, 1'b0);
        chk("reset_rd_err", rd_err, 1'b0);
        chk("reset_busy", busy, 1'b0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        // Good frame at 5 MHz sclk, with latency from cs_n rise to rd_valid.
        send_frame(32'hA5C3, 16, 5);
        model_frame(32'hA5C3, 16);
        lat = 0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            if (rd_valid) begin
                lat = c;
                break;
            end
        end
        chk("good_latency", lat, 3);
        settle_check("good_a5c3");

        // Back-to-back with two sclk periods of cs_n high.
        send_frame(32'h0001, 16, 5);
        model_frame(32'h0001, 16);
        #400;
        send_frame(32'hFFFF, 16, 5);
        model_frame(32'hFFFF, 16);
        settle_check("b2b");

        // Short, long and empty frames.
        send_frame(32'h7FFF, 15, 5);
        model_frame(32'h7FFF, 15);
        settle_check("short15");
        send_frame(32'h1ABCD, 17, 5);
        model_frame(32'h1ABCD, 17);
        settle_check("long17");
        send_frame(32'h0, 0, 5);
        model_frame(32'h0, 0);
        settle_check("zero_len");

        // Reset pulse after bit 8; the tail of that frame must be ignored.
        fork
            send_frame(32'h1234, 16, 5);
            begin
                #(100 + 8 * 200 + 20);
                rst_n = 1'b0;
                #40;
                rst_n = 1'b1;
            end
        join
        model_data = 16'h0;
        settle_check("reset_mid");
        send_frame(32'h5678, 16, 5);
        model_frame(32'h5678, 16);
        settle_check("after_reset");

        // Reset released while a frame is already open.
        rst_n = 1'b0;
        fork
            send_frame(32'hBEEF, 16, 5);
            begin
                #(100 + 5 * 200);
                rst_n = 1'b1;
                #200;
                chk("arm_busy", busy, 1'b0);
            end
        join
        model_data = 16'h0;
        settle_check("release_mid");
        send_frame(32'h5A5A, 16, 5);
        model_frame(32'h5A5A, 16);
        settle_check("after_release");

        // Loopback-style random words at random sclk rates (clk >= 4x sclk).
        for (int k = 0; k < 100; k++) begin
            w  = 32'($urandom_range(0, 65535));
            hp = $urandom_range(2, 5);
            send_frame(w, 16, hp);
            model_frame(w, 16);
            #(hp * 40);
            settle_check($sformatf("rand%0d", k));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
